// File: rtl/ball_engine_multi.sv
// Multi-ball engine: each frame tick moves NB_BALLS balls in turn, bouncing them off walls, paddle and bricks.
// Optional feature macro BALL_SPEEDUP_EN: step grows by 1 every 8 brick hits, capped at 2*STEP.
module ball_engine_multi #(
    parameter int NB_BALLS    = 2,
    parameter int COORD_W     = 11,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int BALL_SIZE   = 8,
    parameter int STEP        = 2,
    parameter int PADDLE_Y    = 460,
    parameter int PADDLE_W    = 64,
    parameter int BRICK_COLS  = 16,
    parameter int BRICK_ROWS  = 8,
    parameter int BRICK_W_L2  = 5,
    parameter int BRICK_H_L2  = 4,
    parameter int BRICK_ADR_W = 9,
    parameter int BRICK_LAT   = 2
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset_n,
    input  logic                        en_export,
    input  logic [COORD_W-1:0]          pos_raquette_export,
    output logic [BRICK_ADR_W-1:0]      adr_brique_export,
    input  logic                        brique_morte_export,
    output logic                        brique_hit,
    output logic [NB_BALLS*COORD_W-1:0] x_position_export,
    output logic [NB_BALLS*COORD_W-1:0] y_position_export,
    output logic [NB_BALLS-1:0]         ball_alive,
    output logic                        perdu_export,
    output logic                        fincalcul_export,
    output logic                        busy
);
    localparam int IDX_W  = (NB_BALLS > 1) ? $clog2(NB_BALLS) : 1;
    localparam int WAIT_W = (BRICK_LAT > 1) ? $clog2(BRICK_LAT) : 1;
    localparam int SW     = COORD_W + 1;

    localparam logic signed [SW-1:0] L_ZERO = '0;
    localparam logic signed [SW-1:0] L_BS   = SW'(BALL_SIZE);
    localparam logic signed [SW-1:0] L_SCW  = SW'(SCREEN_W);
    localparam logic signed [SW-1:0] L_SCH  = SW'(SCREEN_H);
    localparam logic signed [SW-1:0] L_PDY  = SW'(PADDLE_Y);

    typedef enum logic [2:0] {S_IDLE, S_MOVE, S_LOOKUP, S_WAIT, S_RESOLVE, S_DONE} state_t;

    state_t                  r_state, w_next;
    logic [COORD_W-1:0]      r_x [NB_BALLS];
    logic [COORD_W-1:0]      r_y [NB_BALLS];
    logic [NB_BALLS-1:0]     r_dx, r_dy, r_alive;
    logic [IDX_W-1:0]        r_idx;
    logic [WAIT_W-1:0]       r_wait;
    logic [BRICK_ADR_W-1:0]  r_adr;
    logic                    r_nobrick, r_hit, r_perdu, r_fin, r_busy;

    logic [COORD_W-1:0]      w_step, w_x_cur, w_y_cur, w_new_x, w_new_y;
    logic                    w_dx_cur, w_dy_cur, w_new_dx, w_new_dy, w_lost;
    logic                    w_last, w_overlap, w_in_zone, w_hit_now;
    logic signed [SW-1:0]    w_stp, w_xs, w_ys, w_nx, w_ny;
    logic [SW-1:0]           w_xu, w_pu, w_cx, w_cy, w_row, w_col;
    logic [BRICK_ADR_W-1:0]  w_adr;

`ifdef BALL_SPEEDUP_EN
    logic [2:0]          r_hits;
    logic [COORD_W-1:0]  r_step;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_hits <= '0;
            r_step <= COORD_W'(STEP);
        end else if (w_hit_now) begin
            r_hits <= r_hits + 3'd1;
            if (r_hits == 3'd7 && r_step < COORD_W'(2 * STEP))
                r_step <= r_step + COORD_W'(1);
        end
    end
    assign w_step = r_step;
`else
    assign w_step = COORD_W'(STEP);
`endif

    assign w_x_cur   = r_x[r_idx];
    assign w_y_cur   = r_y[r_idx];
    assign w_dx_cur  = r_dx[r_idx];
    assign w_dy_cur  = r_dy[r_idx];
    assign w_last    = (r_idx == IDX_W'(NB_BALLS - 1));
    assign w_hit_now = (r_state == S_RESOLVE) && !brique_morte_export && !r_nobrick && r_alive[r_idx];

    // Candidate positions carry one extra sign bit so a move past 0 shows up as negative
    assign w_stp = signed'({1'b0, w_step});
    assign w_xs  = signed'({1'b0, w_x_cur});
    assign w_ys  = signed'({1'b0, w_y_cur});
    assign w_nx  = w_dx_cur ? (w_xs + w_stp) : (w_xs - w_stp);
    assign w_ny  = w_dy_cur ? (w_ys + w_stp) : (w_ys - w_stp);

    assign w_xu      = {1'b0, w_x_cur};
    assign w_pu      = {1'b0, pos_raquette_export};
    assign w_overlap = (w_xu < w_pu + SW'(PADDLE_W)) && (w_xu + SW'(BALL_SIZE) > w_pu);

    always_comb begin
        w_new_x  = w_x_cur;
        w_new_dx = w_dx_cur;
        w_new_y  = w_y_cur;
        w_new_dy = w_dy_cur;
        w_lost   = 1'b0;
        if (w_nx <= L_ZERO) begin
            w_new_x  = '0;
            w_new_dx = 1'b1;
        end else if (w_nx + L_BS >= L_SCW) begin
            w_new_x  = COORD_W'(SCREEN_W - BALL_SIZE);
            w_new_dx = 1'b0;
        end else begin
            w_new_x = w_nx[COORD_W-1:0];
        end
        if (w_ny <= L_ZERO) begin
            w_new_y  = '0;
            w_new_dy = 1'b1;
        end else if (w_dy_cur && (w_ny + L_BS >= L_PDY) && (w_ys + L_BS < L_PDY) && w_overlap) begin
            w_new_y  = COORD_W'(PADDLE_Y - BALL_SIZE);
            w_new_dy = 1'b0;
        end else if (w_ny + L_BS >= L_SCH) begin
            w_lost   = 1'b1;
            w_new_x  = w_x_cur;
            w_new_dx = w_dx_cur;
        end else begin
            w_new_y = w_ny[COORD_W-1:0];
        end
    end

    assign w_cx      = w_xu + SW'(BALL_SIZE / 2);
    assign w_cy      = {1'b0, w_y_cur} + SW'(BALL_SIZE / 2);
    assign w_in_zone = (w_cy < SW'(BRICK_ROWS << BRICK_H_L2)) && (w_cx < SW'(BRICK_COLS << BRICK_W_L2));
    assign w_row     = w_cy >> BRICK_H_L2;
    assign w_col     = w_cx >> BRICK_W_L2;
    assign w_adr     = BRICK_ADR_W'(w_row * SW'(BRICK_COLS) + w_col);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) r_state <= S_IDLE;
        else                r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (en_export) w_next = S_MOVE;
            S_MOVE:    w_next = S_LOOKUP;
            S_LOOKUP:  w_next = S_WAIT;
            S_WAIT:    if (r_wait == WAIT_W'(BRICK_LAT - 1)) w_next = S_RESOLVE;
            S_RESOLVE: w_next = w_last ? S_DONE : S_MOVE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < NB_BALLS; i++) begin
                r_x[i]     <= COORD_W'(SCREEN_W / 2 + i * 2 * BALL_SIZE);
                r_y[i]     <= COORD_W'(SCREEN_H / 2);
                r_dx[i]    <= (i % 2 == 0);
                r_dy[i]    <= 1'b0;
                r_alive[i] <= 1'b1;
            end
            r_idx     <= '0;
            r_wait    <= '0;
            r_adr     <= '0;
            r_nobrick <= 1'b1;
            r_hit     <= 1'b0;
            r_perdu   <= 1'b0;
            r_fin     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_hit  <= 1'b0;
            r_fin  <= (w_next == S_DONE);
            r_busy <= (w_next != S_IDLE);
            unique case (r_state)
                S_IDLE: r_idx <= '0;
                S_MOVE: begin
                    r_wait <= '0;
                    if (r_alive[r_idx]) begin
                        r_x[r_idx]  <= w_new_x;
                        r_y[r_idx]  <= w_new_y;
                        r_dx[r_idx] <= w_new_dx;
                        r_dy[r_idx] <= w_new_dy;
                        if (w_lost) r_alive[r_idx] <= 1'b0;
                    end
                end
                S_LOOKUP: begin
                    r_nobrick <= !w_in_zone;
                    if (w_in_zone) r_adr <= w_adr;
                end
                S_WAIT: r_wait <= r_wait + WAIT_W'(1);
                S_RESOLVE: begin
                    // Brick reply is only trusted here, BRICK_LAT cycles after the address settled
                    if (w_hit_now) begin
                        r_hit       <= 1'b1;
                        r_dy[r_idx] <= ~r_dy[r_idx];
                    end
                    if (!w_last) r_idx <= r_idx + IDX_W'(1);
                end
                S_DONE: if (r_alive == '0) r_perdu <= 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NB_BALLS; i++) begin
            x_position_export[i*COORD_W +: COORD_W] = r_x[i];
            y_position_export[i*COORD_W +: COORD_W] = r_y[i];
        end
    end

    assign adr_brique_export = r_adr;
    assign brique_hit        = r_hit;
    assign ball_alive        = r_alive;
    assign perdu_export      = r_perdu;
    assign fincalcul_export  = r_fin;
    assign busy              = r_busy;
endmodule

// File: tb/tb_ball_engine_multi.sv
// Bench for ball_engine_multi: random paddle/brick traffic checked against a frame-level behavioural model.
module tb_ball_engine_multi;
    localparam int NB    = 2;
    localparam int CW    = 11;
    localparam int FRAME = NB * (2 + 3);

    logic            clk = 1'b0;
    logic            rst_n, en, morte, hit, perdu, fin, bsy;
    logic [CW-1:0]   pad_in;
    logic [8:0]      adr;
    logic [NB*CW-1:0] xs, ys;
    logic [NB-1:0]   alive;

    ball_engine_multi dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .en_export(en),
        .pos_raquette_export(pad_in), .adr_brique_export(adr),
        .brique_morte_export(morte), .brique_hit(hit),
        .x_position_export(xs), .y_position_export(ys), .ball_alive(alive),
        .perdu_export(perdu), .fincalcul_export(fin), .busy(bsy)
    );

    always #5 clk = ~clk;

    // Brick memory with a two-cycle read pipeline; a hit pulse kills the addressed brick
    logic        mem  [512];
    logic        seed [512];
    logic        mem_load;
    logic [8:0]  adr_d1, adr_d2;
    always @(posedge clk) begin
        adr_d1 <= adr;
        adr_d2 <= adr_d1;
        if (mem_load) begin
            for (int k = 0; k < 512; k++) mem[k] <= seed[k];
        end else if (hit) begin
            mem[adr] <= 1'b1;
        end
    end
    assign morte = mem[adr_d2];

    int n_vec = 0;
    int n_err = 0;
    int m_x [NB], m_y [NB];
    bit m_dx [NB], m_dy [NB], m_alive [NB];
    bit m_perdu;
    int m_step, m_hits;
    int exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int dut_x(input int b);
        return int'(xs[b*CW +: CW]);
    endfunction
    function automatic int dut_y(input int b);
        return int'(ys[b*CW +: CW]);
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NB; b++) begin
            m_x[b] = 320 + b * 16;
            m_y[b] = 240;
            m_dx[b] = (b % 2 == 0);
            m_dy[b] = 1'b0;
            m_alive[b] = 1'b1;
        end
        m_perdu = 1'b0;
        m_step = 2;
        m_hits = 0;
    endtask

    // One frame of game rules, balls in index order, bricks consumed as they are hit
    task automatic model_frame(input int pad);
        bit dl [128];
        int nx, ny, cx, cy, a;
        bit lost;
        for (int k = 0; k < 128; k++) dl[k] = mem[k];
        for (int b = 0; b < NB; b++) begin
            if (m_alive[b]) begin
                nx = m_dx[b] ? m_x[b] + m_step : m_x[b] - m_step;
                ny = m_dy[b] ? m_y[b] + m_step : m_y[b] - m_step;
                lost = 1'b0;
                if (ny <= 0) begin
                    ny = 0; m_dy[b] = 1'b1;
                end else if (m_dy[b] && ny + 8 >= 460 && m_y[b] + 8 < 460 &&
                             m_x[b] < pad + 64 && m_x[b] + 8 > pad) begin
                    ny = 452; m_dy[b] = 1'b0;
                end else if (ny + 8 >= 480) begin
                    lost = 1'b1;
                end
                if (lost) begin
                    m_alive[b] = 1'b0;
                end else begin
                    if (nx <= 0) begin
                        nx = 0; m_dx[b] = 1'b1;
                    end else if (nx + 8 >= 640) begin
                        nx = 632; m_dx[b] = 1'b0;
                    end
                    m_x[b] = nx;
                    m_y[b] = ny;
                end
            end
            if (m_alive[b]) begin
                cx = m_x[b] + 4;
                cy = m_y[b] + 4;
                if (cy < 128 && cx < 512) begin
                    a = (cy / 16) * 16 + cx / 32;
                    if (!dl[a]) begin
                        dl[a] = 1'b1;
                        m_dy[b] = !m_dy[b];
                        exp_q.push_back(a);
`ifdef BALL_SPEEDUP_EN
                        m_hits = (m_hits + 1) % 8;
                        if (m_hits == 0 && m_step < 4) m_step++;
`endif
                    end
                end
            end
        end
        if (!m_alive[0] && !m_alive[NB-1]) m_perdu = 1'b1;
    endtask

    task automatic check_reset_state(input string w);
        for (int b = 0; b < NB; b++) begin
            check($sformatf("%s_x%0d", w, b), dut_x(b), 320 + b * 16);
            check($sformatf("%s_y%0d", w, b), dut_y(b), 240);
        end
        check({w, "_alive"}, alive, 2'b11);
        check({w, "_adr"}, adr, 0);
        check({w, "_hit"}, hit, 0);
        check({w, "_perdu"}, perdu, 0);
        check({w, "_fin"}, fin, 0);
        check({w, "_busy"}, bsy, 0);
    endtask

    task automatic run_frame(input int pad, input int en_at, input int rst_at);
        int n_exp, n_obs, a, x1_prev;
        pad_in = CW'(pad);
        x1_prev = dut_x(NB - 1);
        exp_q.delete();
        model_frame(pad);
        n_exp = exp_q.size();
        n_obs = 0;
        @(negedge clk); en = 1'b1;
        @(negedge clk); en = 1'b0;
        for (int k = 0; k <= FRAME + 1; k++) begin
            if (k == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_state("midrst");
                model_reset();
                exp_q.delete();
                @(negedge clk); rst_n = 1'b1;
                return;
            end
            check($sformatf("fin_k%0d", k), fin, (k == FRAME));
            check($sformatf("busy_k%0d", k), bsy, (k <= FRAME));
            if (k == 4) check("x1_hold", dut_x(NB - 1), x1_prev);
            if (hit) begin
                n_obs++;
                if (exp_q.size() == 0) begin
                    check("hit_extra", 1, 0);
                end else begin
                    a = exp_q.pop_front();
                    check("hit_adr", adr, a);
                end
            end
            en = (k == en_at);
            @(negedge clk);
        end
        en = 1'b0;
        check("hit_count", n_obs, n_exp);
        check("busy_after", bsy, 0);
        for (int b = 0; b < NB; b++) begin
            check($sformatf("x%0d", b), dut_x(b), m_x[b]);
            check($sformatf("y%0d", b), dut_y(b), m_y[b]);
            check($sformatf("alive%0d", b), alive[b], m_alive[b]);
        end
        check("perdu", perdu, m_perdu);
    endtask

    initial begin
        int pad, t, en_at;
        rst_n = 1'b0; en = 1'b0; pad_in = '0; mem_load = 1'b0;
        for (int k = 0; k < 512; k++) seed[k] = (k < 128) ? ($urandom_range(0, 3) != 0) : 1'b1;
        model_reset();
        @(negedge clk); mem_load = 1'b1;
        @(negedge clk); mem_load = 1'b0;
        check_reset_state("por");
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        run_frame(300, -1, -1);
        check("f1_x0", dut_x(0), 322);
        check("f1_y0", dut_y(0), 238);
        check("f1_x1", dut_x(1), 334);

        // Paddle mostly tracks a live ball so play reaches the brick zone
        for (int f = 0; f < 150; f++) begin
            if ($urandom_range(0, 7) == 0 || (!m_alive[0] && !m_alive[1])) begin
                pad = int'($urandom_range(0, 639));
            end else begin
                t = (m_alive[0] && (!m_alive[1] || $urandom_range(0, 1) == 0)) ? 0 : 1;
                pad = m_x[t] - int'($urandom_range(0, 56));
                if (pad < 0) pad = 0;
            end
            en_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, FRAME)) : -1;
            run_frame(pad, en_at, -1);
        end

        // All bricks gone and paddle off-screen: both balls must drain out
        for (int k = 0; k < 512; k++) seed[k] = 1'b1;
        @(negedge clk); mem_load = 1'b1;
        @(negedge clk); mem_load = 1'b0;
        for (int f = 0; f < 600 && !m_perdu; f++) begin
            en_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, FRAME)) : -1;
            run_frame(2000, en_at, -1);
        end
        check("perdu_final", perdu, 1);
        check("alive_final", alive, 2'b00);
        for (int f = 0; f < 3; f++) run_frame(int'($urandom_range(0, 639)), -1, -1);

        for (int k = 0; k < 512; k++) seed[k] = (k < 128) ? ($urandom_range(0, 1) != 0) : 1'b1;
        @(negedge clk); mem_load = 1'b1;
        @(negedge clk); mem_load = 1'b0;
        run_frame(300, -1, 3);
        run_frame(300, -1, -1);
        check("post_rst_x0", dut_x(0), 322);
        check("post_rst_y1", dut_y(1), 238);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
